// File: rtl/lint_apb_bridge.sv
// lint_apb_bridge
//   Converts LINT/TCDM master requests from the JTAG debug path into single
//   APB4 transfers. Only one transaction is in flight at a time:
//   grant (IDLE) -> SETUP -> ACCESS (until pready) -> one-cycle response (RESP).
//
// Optional feature (macro LINT_APB_TIMEOUT_EN):
//   When defined, an ACCESS phase that sees no pready_i for TIMEOUT_CYCLES
//   cycles is abandoned and answered with an error response and zero data.
//   When undefined, ACCESS waits for pready_i indefinitely.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   lint_req_i/lint_gnt_o    LINT request / grant (grant only in IDLE)
//   lint_add_i, lint_wen_i,  request address, 1=read/0=write,
//   lint_wdata_i, lint_be_i  write data, byte enables
//   lint_r_valid_o           one-cycle response pulse
//   lint_r_rdata_o           captured read data (holds between responses)
//   lint_r_opc_o             response error (slave error or timeout)
//   paddr_o .. pprot_o       APB4 master request outputs
//   prdata_i, pready_i,      APB4 completion inputs
//   pslverr_i
module lint_apb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      lint_req_i,
    input  logic [ADDR_WIDTH-1:0]     lint_add_i,
    input  logic                      lint_wen_i,
    input  logic [DATA_WIDTH-1:0]     lint_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   lint_be_i,
    output logic                      lint_gnt_o,
    output logic                      lint_r_valid_o,
    output logic [DATA_WIDTH-1:0]     lint_r_rdata_o,
    output logic                      lint_r_opc_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic [DATA_WIDTH-1:0]     pwdata_o,
    output logic [DATA_WIDTH/8-1:0]   pstrb_o,
    output logic [2:0]                pprot_o,
    input  logic [DATA_WIDTH-1:0]     prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                    state;
    logic [ADDR_WIDTH-1:0]     add_q;
    logic                      pwrite_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH/8-1:0]   strb_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic                      err_q;
    logic                      psel_q;
    logic                      penable_q;
    logic                      rvalid_q;
    logic                      timeout;

    // Byte-offset bits (and any bits above the APB range) are dropped on the
    // APB side; this keeps them visibly consumed.
    logic unused_addr;
    assign unused_addr = ^add_q;

`ifdef LINT_APB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // cnt holds the number of stalled ACCESS cycles already seen, so the
    // cycle with cnt == TIMEOUT_CYCLES-1 and no pready is the one in which
    // the count reaches TIMEOUT_CYCLES; the transfer is abandoned on its edge.
    // A pready in that same cycle takes the normal completion path instead.
    assign timeout = (state == ACCESS) && !pready_i && (cnt == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (state == SETUP) begin
            cnt <= '0;
        end else if (state == ACCESS && !pready_i) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= IDLE;
            add_q     <= '0;
            pwrite_q  <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (lint_req_i) begin
                        add_q    <= lint_add_i;
                        pwrite_q <= ~lint_wen_i;
                        wdata_q  <= lint_wdata_i;
                        // Reads never carry strobes on APB4.
                        strb_q   <= lint_wen_i ? '0 : lint_be_i;
                        psel_q   <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (pready_i) begin
                        rdata_q   <= prdata_i;
                        err_q     <= pslverr_i;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        state     <= RESP;
                    end else if (timeout) begin
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rvalid_q <= 1'b0;
                    err_q    <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Grant is combinational so a waiting request is accepted in the same
    // cycle the bridge becomes idle.
    assign lint_gnt_o     = (state == IDLE) && lint_req_i && rst_ni;
    assign lint_r_valid_o = rvalid_q;
    assign lint_r_rdata_o = rdata_q;
    assign lint_r_opc_o   = err_q;

    assign paddr_o   = {add_q[APB_ADDR_WIDTH-1:2], 2'b00};
    assign pwrite_o  = pwrite_q;
    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign pwdata_o  = wdata_q;
    assign pstrb_o   = strb_q;
    assign pprot_o   = 3'b000;

endmodule

// File: tb/tb_lint_apb_bridge.sv
module tb_lint_apb_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        opc;
    logic [31:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    lint_apb_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .APB_ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .lint_req_i(req), .lint_add_i(add), .lint_wen_i(wen),
        .lint_wdata_i(wdata), .lint_be_i(be), .lint_gnt_o(gnt),
        .lint_r_valid_o(rv), .lint_r_rdata_o(rdata), .lint_r_opc_o(opc),
        .paddr_o(paddr), .pwrite_o(pwrite), .psel_o(psel), .penable_o(penable),
        .pwdata_o(pwdata), .pstrb_o(pstrb), .pprot_o(pprot),
        .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level reference: a granted transaction at cycle g with
    // s stall cycles occupies cycles g..g+3+s (SETUP g+1, ACCESS g+2..g+2+s,
    // response g+3+s); the bridge is free again at g+4+s.
    int          cyc = 0;
    bit          active = 0;
    int          g, s;
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic        t_wen, t_err, t_to;
    logic [3:0]  t_be;
    logic [31:0] rdata_hold = '0;

    bit          force_en = 0, force_data = 0, force_to = 0;
    int          f_stall;
    logic [31:0] f_rdata;
    logic        f_err;

    int          n_gnt = 0, n_rv = 0, last_gnt_cyc = 0, last_rv_cyc = 0, acc_cycles = 0;
    logic [31:0] obs_paddr, obs_pwdata, obs_rdata;
    logic        obs_pwrite, obs_opc;
    logic [3:0]  obs_pstrb;

    task automatic step(input logic r, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] b, input logic rn);
        bit e_psel, e_pen, e_rv, e_gnt;
        rst_n = rn; req = r; add = a; wen = w; wdata = d; be = b;
        if (active && cyc == g + 2 + s) begin
            pready  = t_to ? 1'b0 : 1'b1;
            prdata  = t_rdata;
            pslverr = t_err;
        end else if (active && cyc >= g + 2) begin
            pready  = 1'b0;
            prdata  = $urandom;
            pslverr = 1'($urandom);
        end else begin
            pready  = 1'($urandom);
            prdata  = $urandom;
            pslverr = 1'($urandom);
        end
        #1;
        e_psel = active && cyc >= g + 1 && cyc <= g + 2 + s;
        e_pen  = active && cyc >= g + 2 && cyc <= g + 2 + s;
        e_rv   = active && cyc == g + 3 + s;
        e_gnt  = r && !active;
        if (e_rv) rdata_hold = t_to ? 32'h0 : t_rdata;
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("psel", 32'(psel), 32'(e_psel));
        chk("penable", 32'(penable), 32'(e_pen));
        chk("r_valid", 32'(rv), 32'(e_rv));
        chk("r_rdata", rdata, rdata_hold);
        chk("r_opc", 32'(opc), e_rv ? 32'(t_to | t_err) : 32'h0);
        chk("pprot", 32'(pprot), 32'h0);
        if (e_psel) begin
            chk("paddr", paddr, {t_addr[31:2], 2'b00});
            chk("pwrite", 32'(pwrite), 32'(!t_wen));
            chk("pwdata", pwdata, t_wdata);
            chk("pstrb", 32'(pstrb), t_wen ? 32'h0 : 32'(t_be));
        end
        if (gnt) begin n_gnt++; last_gnt_cyc = cyc; end
        if (psel && !penable) begin
            obs_paddr = paddr; obs_pwrite = pwrite; obs_pstrb = pstrb; obs_pwdata = pwdata;
        end
        if (psel && penable) acc_cycles++;
        if (rv) begin n_rv++; last_rv_cyc = cyc; obs_rdata = rdata; obs_opc = opc; end
        if (!rn) begin
            active = 0;
            rdata_hold = '0;
        end else begin
            if (e_rv) active = 0;
            if (e_gnt) begin
                active = 1; g = cyc;
                t_addr = a; t_wen = w; t_wdata = d; t_be = b;
                t_to    = force_to;
                s       = force_en ? f_stall : int'($urandom_range(0, 4));
                t_rdata = force_data ? f_rdata : $urandom;
                t_err   = force_data ? f_err : 1'($urandom);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic rnd_step(input logic r);
        step(r, $urandom, 1'($urandom), $urandom, 4'($urandom), 1'b1);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          stall;
        logic [31:0] prd;
        logic        err;
        logic [31:0] e_paddr;
        logic        e_pwrite;
        logic [3:0]  e_pstrb;
        logic [31:0] e_rdata;
        logic        e_opc;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v, input string nm);
        int rv0, gn0, k;
        force_en = 1; force_data = 1;
        f_stall = v.stall; f_rdata = v.prd; f_err = v.err;
        rv0 = n_rv; gn0 = n_gnt; acc_cycles = 0;
        step(1'b1, v.addr, v.wen, v.wdata, v.be, 1'b1);
        chk({nm, " granted"}, 32'(n_gnt - gn0), 32'd1);
        k = 0;
        while (n_rv == rv0 && k < 40) begin
            rnd_step(1'b0);
            k++;
        end
        chk({nm, " responses"}, 32'(n_rv - rv0), 32'd1);
        chk({nm, " paddr"}, obs_paddr, v.e_paddr);
        chk({nm, " pwrite"}, 32'(obs_pwrite), 32'(v.e_pwrite));
        chk({nm, " pstrb"}, 32'(obs_pstrb), 32'(v.e_pstrb));
        if (!v.wen) chk({nm, " pwdata"}, obs_pwdata, v.wdata);
        chk({nm, " rdata"}, obs_rdata, v.e_rdata);
        chk({nm, " opc"}, 32'(obs_opc), 32'(v.e_opc));
        chk({nm, " latency"}, 32'(last_rv_cyc - last_gnt_cyc), 32'(3 + v.stall));
        chk({nm, " access cycles"}, 32'(acc_cycles), 32'(v.stall + 1));
        force_en = 0; force_data = 0;
        rnd_step(1'b0);
    endtask

    initial begin
        int gn0, rv0, first_g, k;
        vec_t rd_after;

        vecs[0] = '{32'h1A10_0004, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 32'hCAFE_F00D, 1'b0,
                    32'h1A10_0004, 1'b0, 4'h0, 32'hCAFE_F00D, 1'b0};
        vecs[1] = '{32'h1A10_0008, 1'b0, 32'h1234_5678, 4'b0011, 5, 32'h5555_AAAA, 1'b0,
                    32'h1A10_0008, 1'b1, 4'b0011, 32'h5555_AAAA, 1'b0};
        vecs[2] = '{32'h1A10_0010, 1'b1, 32'h0, 4'hF, 2, 32'h0BAD_0BAD, 1'b1,
                    32'h1A10_0010, 1'b0, 4'h0, 32'h0BAD_0BAD, 1'b1};
        vecs[3] = '{32'h1A10_0014, 1'b1, 32'h0, 4'h1, 1, 32'h0000_1111, 1'b0,
                    32'h1A10_0014, 1'b0, 4'h0, 32'h0000_1111, 1'b0};
        vecs[4] = '{32'h1A10_0027, 1'b0, 32'hA5A5_5A5A, 4'b1100, 0, 32'h0, 1'b0,
                    32'h1A10_0024, 1'b1, 4'b1100, 32'h0, 1'b0};

        rst_n = 1'b0; req = 1'b0; add = '0; wen = 1'b0; wdata = '0; be = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0);
        chk("reset paddr", paddr, 32'h0);
        chk("reset pwrite", 32'(pwrite), 32'h0);
        chk("reset pwdata", pwdata, 32'h0);
        chk("reset pstrb", 32'(pstrb), 32'h0);
        chk("reset rdata", rdata, 32'h0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back: request held high, every transfer completes at once.
        force_en = 1; f_stall = 0;
        gn0 = n_gnt; rv0 = n_rv; first_g = cyc;
        for (int i = 0; i < 16; i++) rnd_step(1'b1);
        chk("b2b grants", 32'(n_gnt - gn0), 32'd4);
        chk("b2b responses", 32'(n_rv - rv0), 32'd4);
        chk("b2b last grant", 32'(last_gnt_cyc - first_g), 32'd12);
        force_en = 0;
        for (int i = 0; i < 4; i++) rnd_step(1'b0);

        // Reset while the APB slave is stalling in ACCESS.
        force_en = 1; f_stall = 10;
        rv0 = n_rv;
        step(1'b1, 32'h1A10_0030, 1'b0, 32'h7777_8888, 4'hF, 1'b1);
        rnd_step(1'b0);
        rnd_step(1'b0);
        rnd_step(1'b0);
        chk("abort in access", 32'({psel, penable}), 32'd3);
        step(1'b0, '0, 1'b0, '0, '0, 1'b0);
        chk("abort psel", 32'(psel), 32'h0);
        chk("abort penable", 32'(penable), 32'h0);
        chk("abort paddr", paddr, 32'h0);
        chk("abort pwdata", pwdata, 32'h0);
        chk("abort pstrb", 32'(pstrb), 32'h0);
        chk("abort pwrite", 32'(pwrite), 32'h0);
        force_en = 0;
        for (int i = 0; i < 14; i++) rnd_step(1'b0);
        chk("abort no r_valid", 32'(n_rv - rv0), 32'd0);
        run_vec(vecs[0], "after reset");

`ifdef LINT_APB_TIMEOUT_EN
        // Slave never answers: error response with zero data after TO ACCESS cycles.
        force_en = 1; force_to = 1; f_stall = TO - 1;
        rv0 = n_rv; acc_cycles = 0;
        step(1'b1, 32'h1A10_0040, 1'b1, '0, 4'hF, 1'b1);
        k = 0;
        while (n_rv == rv0 && k < 40) begin
            rnd_step(1'b0);
            k++;
        end
        force_en = 0; force_to = 0;
        chk("timeout responses", 32'(n_rv - rv0), 32'd1);
        chk("timeout opc", 32'(obs_opc), 32'd1);
        chk("timeout rdata", obs_rdata, 32'h0);
        chk("timeout access cycles", 32'(acc_cycles), 32'(TO));
        rnd_step(1'b0);
`endif

        // Randomised traffic against the transaction-level reference.
        for (int i = 0; i < 400; i++) rnd_step(1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 12; i++) rnd_step(1'b0);
        chk("random traffic drained", 32'(active), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
